// File: rtl/mux_arb_nx1_if.sv
// ---------------------------------------------------------------------------
// mux_arb_nx1_if
//   Bundle of the N-input selector's handshake and data signals.
//
//   Parameters: WIDTH (data bits per channel), NUM_IN (channel count),
//               SEL_W (select width, 2^SEL_W >= NUM_IN).
//
//   Signals:
//     in_data   NUM_IN*WIDTH  flattened channel data, channel k at [k*WIDTH +: WIDTH]
//     in_valid  NUM_IN        per-channel valid
//     in_ready  NUM_IN        per-channel accept strobe (one-hot or zero)
//     sel       SEL_W         channel select for fixed mode
//     mode      1             0 = fixed select, 1 = round-robin
//     out_data  WIDTH         registered selected word
//     out_sel   SEL_W         channel that produced out_data
//     out_valid 1             out_data is valid
//     out_ready 1             consumer accepts out_data
//
//   Modports: master = producers/consumer side driving the selector,
//             slave  = the selector itself.
// ---------------------------------------------------------------------------
interface mux_arb_nx1_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 32,
  parameter int SEL_W  = 5
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// ---------------------------------------------------------------------------
// mux_arb_nx1
//   N-input, W-bit registered selector with per-channel valid/ready
//   handshakes. One channel is picked per cycle, either by the external
//   select or (optionally) by round-robin arbitration, and its word is
//   captured in a single output register that honours backpressure.
//
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  asynchronous, active-high reset
//     bus    mux_arb_nx1_if.slave (channel inputs, select/mode, output stage)
//
//   Build option:
//     MUX_ARB_RR_EN  when defined, the round-robin search and its pointer
//                    are built and bus.mode chooses fixed/round-robin.
//                    When undefined, bus.mode is ignored (fixed select only).
// ---------------------------------------------------------------------------
module mux_arb_nx1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 32,
  parameter int SEL_W  = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mux_arb_nx1_if.slave  bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q,  out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             ld;
  logic             fix_grant;
  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // The output register may take a new word when it is empty or being drained.
  assign ld = ~out_valid_q | bus.out_ready;

  // Fixed select: matching against every in-range index means an out-of-range
  // select simply never matches, so no explicit bound check is needed.
  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fix_grant = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k) && bus.in_valid[k]) fix_grant = 1'b1;
    end
  end

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             hi_found, lo_found;
  logic [SEL_W-1:0] hi_idx, lo_idx;
  logic             rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             mode_rr;

  assign mode_rr = bus.mode;

  // Round-robin search split in two halves: the lowest valid channel above
  // ptr wins; failing that, the lowest valid channel at or below ptr (the
  // wrap-around). Scanning downward lets the last hit be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (bus.in_valid[k]) begin
        if (SEL_W'(k) > ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SEL_W'(k);
        end
      end
    end
    rr_grant = hi_found | lo_found;
    rr_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign grant   = mode_rr ? rr_grant : fix_grant;
  assign gnt_idx = mode_rr ? rr_idx   : bus.sel;

  // The pointer only advances on a round-robin transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (ld && grant && mode_rr) ptr_d = rr_idx;
  end

  // Reset to the last channel so the first search begins at channel 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= SEL_W'(NUM_IN - 1);
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_mode;

  assign unused_mode = bus.mode;
  assign grant       = fix_grant;
  assign gnt_idx     = bus.sel;
`endif

  // Data steering is purely a mux into the register; in_data never reaches
  // an output combinationally.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (gnt_idx == SEL_W'(k)) gnt_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Accept strobe: one-hot on the granted channel, held off during reset.
  always_comb begin
    bus.in_ready = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!rst_i && ld && grant && gnt_idx == SEL_W'(k)) bus.in_ready[k] = 1'b1;
    end
  end

  // Load on grant, drain when nothing is granted, hold while stalled.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (ld) begin
      if (grant) begin
        out_data_d  = gnt_data;
        out_sel_d   = gnt_idx;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_nx1
//   Directed bench for mux_arb_nx1. Instance A has 32 channels; instance B
//   has 16 channels with a 5-bit select so out-of-range selects can occur.
//   Round-robin checks are built when MUX_ARB_RR_EN is defined; otherwise
//   the same stimulus confirms that mode is ignored.
// ---------------------------------------------------------------------------
module tb_mux_arb_nx1;
  localparam int W  = 32;
  localparam int NA = 32;
  localparam int NB = 16;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_seq [5] = '{0, 2, 31, 0, 2};

  mux_arb_nx1_if #(.WIDTH(W), .NUM_IN(NA), .SEL_W(SW)) a_if ();
  mux_arb_nx1_if #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) b_if ();

  mux_arb_nx1 #(.WIDTH(W), .NUM_IN(NA), .SEL_W(SW)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (a_if)
  );

  mux_arb_nx1 #(.WIDTH(W), .NUM_IN(NB), .SEL_W(SW)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic [W-1:0] v);
    a_if.in_data[k*W +: W] = v;
  endtask

  initial begin
    a_if.in_data   = '0;
    a_if.in_valid  = '0;
    a_if.sel       = '0;
    a_if.mode      = 1'b0;
    a_if.out_ready = 1'b0;
    b_if.in_data   = '0;
    b_if.in_valid  = '0;
    b_if.sel       = '0;
    b_if.mode      = 1'b0;
    b_if.out_ready = 1'b0;

    // Reset state, and no accept strobe while reset is high.
    #1;
    a_if.in_valid  = '1;
    a_if.out_ready = 1'b1;
    #1;
    check("rst_in_ready", a_if.in_ready, 64'h0);
    tick();
    check("rst_out_valid", a_if.out_valid, 64'h0);
    check("rst_out_data",  a_if.out_data,  64'h0);
    check("rst_out_sel",   a_if.out_sel,   64'h0);
    a_if.in_valid = '0;
    #2 rst = 1'b0;
    tick();

    // Fixed mode, channel 3.
    set_a(3, 32'hDEAD_BEEF);
    a_if.sel       = 5'd3;
    a_if.in_valid  = 32'h0000_0008;
    a_if.out_ready = 1'b1;
    a_if.mode      = 1'b0;
    #1;
    check("fx_in_ready", a_if.in_ready, 64'h8);
    tick();
    check("fx_out_valid", a_if.out_valid, 64'h1);
    check("fx_out_data",  a_if.out_data,  64'hDEAD_BEEF);
    check("fx_out_sel",   a_if.out_sel,   64'd3);

    // Stall for four cycles with a new word pending.
    set_a(3, 32'h1234_5678);
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready",  a_if.in_ready,  64'h0);
      check("stall_out_valid", a_if.out_valid, 64'h1);
      check("stall_out_data",  a_if.out_data,  64'hDEAD_BEEF);
      check("stall_out_sel",   a_if.out_sel,   64'd3);
      tick();
    end

    // Release: the pending word loads with no bubble.
    a_if.out_ready = 1'b1;
    #1;
    check("nobubble_in_ready", a_if.in_ready, 64'h8);
    tick();
    check("nobubble_out_valid", a_if.out_valid, 64'h1);
    check("nobubble_out_data",  a_if.out_data,  64'h1234_5678);

    // Drain: no valid input, output empties, data/sel hold.
    a_if.in_valid = '0;
    #1;
    check("drain_in_ready", a_if.in_ready, 64'h0);
    tick();
    check("drain_out_valid", a_if.out_valid, 64'h0);
    check("drain_out_data",  a_if.out_data,  64'h1234_5678);
    check("drain_out_sel",   a_if.out_sel,   64'd3);

    // Selected channel not valid: no grant. Then top channel.
    a_if.sel      = 5'd4;
    a_if.in_valid = 32'h0000_0008;
    #1;
    check("fx_unsel_in_ready", a_if.in_ready, 64'h0);
    a_if.sel      = 5'd31;
    a_if.in_valid = 32'h8000_0008;
    set_a(31, 32'hA5A5_0031);
    #1;
    check("fx31_in_ready", a_if.in_ready, 64'h8000_0000);
    tick();
    check("fx31_out_sel",  a_if.out_sel,  64'd31);
    check("fx31_out_data", a_if.out_data, 64'hA5A5_0031);

    // Round-robin (or mode ignored when the option is not built).
    set_a(0,  32'h0000_0100);
    set_a(2,  32'h0000_0102);
    set_a(5,  32'h0000_0105);
    set_a(31, 32'h0000_011F);
    a_if.mode      = 1'b1;
    a_if.sel       = 5'd0;
    a_if.in_valid  = 32'h8000_0005;
    a_if.out_ready = 1'b1;
`ifdef MUX_ARB_RR_EN
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_in_ready", a_if.in_ready, 64'(1) << exp_seq[i]);
      tick();
      check("rr_out_sel",  a_if.out_sel,  64'(exp_seq[i]));
      check("rr_out_data", a_if.out_data, 64'h100 + 64'(exp_seq[i]));
    end
    a_if.in_valid = '0;
    #1;
    check("rr_idle_in_ready", a_if.in_ready, 64'h0);
    tick();
    check("rr_idle_out_valid", a_if.out_valid, 64'h0);
    a_if.in_valid = 32'h0000_0020;
    #1;
    check("rr5_in_ready", a_if.in_ready, 64'h20);
    tick();
    check("rr5_out_sel",   a_if.out_sel,   64'd5);
    check("rr5_out_valid", a_if.out_valid, 64'h1);
    a_if.in_valid = 32'h8000_0005;
    #1;
    check("rr_after5_in_ready", a_if.in_ready, 64'h8000_0000);
    tick();
    check("rr_after5_out_sel", a_if.out_sel, 64'd31);
    a_if.in_valid = 32'h0000_0004;
    tick();
    check("rr_ch2_out_sel", a_if.out_sel, 64'd2);
`else
    a_if.sel = 5'd2;
    #1;
    check("modeig_in_ready", a_if.in_ready, 64'h4);
    tick();
    check("modeig_out_sel",  a_if.out_sel,  64'd2);
    check("modeig_out_data", a_if.out_data, 64'h102);
    a_if.sel = 5'd0;
    #1;
    check("modeig0_in_ready", a_if.in_ready, 64'h1);
    tick();
    check("modeig0_out_sel", a_if.out_sel, 64'd0);
`endif

    // Asynchronous reset while stalled with a valid word.
    a_if.mode      = 1'b0;
    a_if.sel       = 5'd3;
    a_if.in_valid  = 32'h0000_0008;
    set_a(3, 32'hCAFE_F00D);
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    a_if.in_valid  = '0;
    #1;
    check("prerst_out_valid", a_if.out_valid, 64'h1);
    check("prerst_out_data",  a_if.out_data,  64'hCAFE_F00D);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", a_if.out_valid, 64'h0);
    check("arst_out_data",  a_if.out_data,  64'h0);
    check("arst_out_sel",   a_if.out_sel,   64'h0);
    a_if.mode      = 1'b1;
    a_if.sel       = 5'd0;
    a_if.in_valid  = 32'h8000_0005;
    a_if.out_ready = 1'b1;
    #1;
    check("arst_in_ready", a_if.in_ready, 64'h0);
    tick();
    tick();
    check("arst_hold_out_valid", a_if.out_valid, 64'h0);
    #1 rst = 1'b0;
    #1;
    check("rel_in_ready", a_if.in_ready, 64'h1);
    tick();
    check("rel_out_sel",   a_if.out_sel,   64'd0);
    check("rel_out_valid", a_if.out_valid, 64'h1);
    check("rel_out_data",  a_if.out_data,  64'h100);

    // Out-of-range select on the 16-channel instance.
    for (int k = 0; k < NB; k++) b_if.in_data[k*W +: W] = 32'h0000_B000 + 32'(k);
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 16'hFFFF;
    b_if.sel       = 5'd20;
    #1;
    check("oor_in_ready", b_if.in_ready, 64'h0);
    tick();
    check("oor_out_valid", b_if.out_valid, 64'h0);
    b_if.sel = 5'd15;
    #1;
    check("b15_in_ready", b_if.in_ready, 64'h8000);
    tick();
    check("b15_out_sel",  b_if.out_sel,  64'd15);
    check("b15_out_data", b_if.out_data, 64'hB00F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
